// File: rtl/meas_seq_mc.sv
// Multi-channel dual-slope conversion sequencer driving the analog front-end control bus.
// Latency: per channel, ref wait + T_RST + T_AZ + T_INT + deintegrate count + 1 result cycle.
// Backpressure: a pending result holds the sequencer in RESULT (integrator discharged) until result_ready_i.
//
// Ports:
//   clk_i, rst_i (sync, active-high)  start_i, abort_i, continuous_i, ch_mask_i, mode_cfg_i
//   comp_i, sat_hi_i, sat_lo_i, ref_ok_i  asynchronous analog status, double-flopped internally
//   afe_sel_o, range_sel_o, afe_reset_o, ref_sign_o, mode_sel_o, ch_sel_o, busy_o  front-end control
//   result_valid_o/result_ready_i handshake with result_o, result_sign_o, result_ch_o,
//   result_range_o, result_ovr_o
// Optional macro AUTORANGE_EN: per-channel autorange (up on overrange with silent retry,
// down after an underrange result). Without it the range is fixed at N_RANGE-1.
module meas_seq_mc #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int T_RST     = 16,
    parameter int T_AZ      = 256,
    parameter int T_INT     = 1000,
    parameter int N_RANGE   = 5,
    parameter int UNDER_DIV = 10,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                continuous_i,
    input  logic [NUM_CH-1:0]   ch_mask_i,
    input  logic [3*NUM_CH-1:0] mode_cfg_i,
    input  logic                comp_i,
    input  logic                sat_hi_i,
    input  logic                sat_lo_i,
    input  logic                ref_ok_i,
    output logic [3:0]          afe_sel_o,
    output logic [4:0]          range_sel_o,
    output logic                afe_reset_o,
    output logic                ref_sign_o,
    output logic [2:0]          mode_sel_o,
    output logic [CH_W-1:0]     ch_sel_o,
    output logic                busy_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [CNT_W-1:0]    result_o,
    output logic                result_sign_o,
    output logic [CH_W-1:0]     result_ch_o,
    output logic [4:0]          result_range_o,
    output logic                result_ovr_o
);

    localparam int TMAX  = (T_INT > T_AZ) ? ((T_INT > T_RST) ? T_INT : T_RST)
                                          : ((T_AZ > T_RST) ? T_AZ : T_RST);
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [4:0] RANGE_TOP = 5'(N_RANGE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_WAIT_REF, S_DISCH, S_AZ, S_INT, S_DEINT, S_RESULT
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [2:0]        mode_q, mode_d;
    logic              first_q, first_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              p_q, p_d;
    logic              ovr_q, ovr_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic              res_sign_q, res_sign_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic [4:0]        res_range_q, res_range_d;
    logic              res_ovr_q, res_ovr_d;

    // Synchronised analog status: [0] comp, [1] sat_hi, [2] sat_lo, [3] ref_ok
    logic comp_s, sat_hi_s, sat_lo_s, ref_ok_s;
    assign comp_s   = sync2_q[0];
    assign sat_hi_s = sync2_q[1];
    assign sat_lo_s = sync2_q[2];
    assign ref_ok_s = sync2_q[3];

    logic [4:0] cur_range;
`ifdef AUTORANGE_EN
    localparam int UNDER_TH = T_INT / UNDER_DIV;
    logic [4:0] range_q [NUM_CH];
    logic [4:0] range_d [NUM_CH];
    assign cur_range = range_q[ch_q];
`else
    assign cur_range = RANGE_TOP;
`endif

    // Channel search over the latched mask
    logic [CH_W-1:0] lowest, next_above;
    logic            found_above;
    always_comb begin
        lowest      = '0;
        next_above  = '0;
        found_above = 1'b0;
        // Descending walk: the last hit is the lowest qualifying channel
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                lowest = CH_W'(k);
                if (k > int'(ch_q)) begin
                    next_above  = CH_W'(k);
                    found_above = 1'b1;
                end
            end
        end
    end

    logic            go;
    logic [CH_W-1:0] sel;
    logic [2:0]      mode_pick;
    logic            done, ovr_fin, retry;

    always_comb begin
        sync1_d     = {ref_ok_i, sat_lo_i, sat_hi_i, comp_i};
        sync2_d     = sync1_q;
        state_d     = state_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        mode_d      = mode_q;
        first_d     = first_q;
        timer_d     = timer_q;
        count_d     = count_q;
        p_d         = p_q;
        ovr_d       = ovr_q;
        valid_d     = valid_q;
        res_cnt_d   = res_cnt_q;
        res_sign_d  = res_sign_q;
        res_ch_d    = res_ch_q;
        res_range_d = res_range_q;
        res_ovr_d   = res_ovr_q;
        go          = 1'b0;
        sel         = lowest;
        mode_pick   = 3'd0;
        done        = 1'b0;
        ovr_fin     = ovr_q;
        retry       = 1'b0;
`ifdef AUTORANGE_EN
        range_d     = range_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i && (|ch_mask_i)) begin
                    mask_d  = ch_mask_i;
                    first_d = 1'b1;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                first_d = 1'b0;
                if (first_q) begin
                    go = 1'b1;
                end else if (found_above) begin
                    go  = 1'b1;
                    sel = next_above;
                end else if (continuous_i) begin
                    go = 1'b1;
                end
                for (int k = 0; k < NUM_CH; k++) begin
                    if (CH_W'(k) == sel) mode_pick = mode_cfg_i[3*k +: 3];
                end
                if (go) begin
                    ch_d    = sel;
                    mode_d  = mode_pick;
                    state_d = S_WAIT_REF;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_REF: begin
                if (ref_ok_s) begin
                    state_d = S_DISCH;
                    timer_d = '0;
                    ovr_d   = 1'b0;
                end
            end
            S_DISCH: begin
                if (timer_q == TMR_W'(T_RST - 1)) begin
                    state_d = S_AZ;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_AZ: begin
                if (timer_q == TMR_W'(T_AZ - 1)) begin
                    state_d = S_INT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_INT: begin
                if (sat_hi_s || sat_lo_s) ovr_d = 1'b1;
                if (timer_q == TMR_W'(T_INT - 1)) begin
                    // Polarity of the integrated charge decides the reference sign
                    state_d = S_DEINT;
                    p_d     = comp_s;
                    count_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DEINT: begin
                if (comp_s != p_q) begin
                    done = 1'b1;
                end else if (count_q == CNT_W'(2 * T_INT)) begin
                    done    = 1'b1;
                    ovr_fin = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
`ifdef AUTORANGE_EN
                if (done && ovr_fin && (cur_range < RANGE_TOP)) begin
                    // Overrange on a sensitive range: step up and reconvert silently
                    retry          = 1'b1;
                    range_d[ch_q]  = cur_range + 5'd1;
                    state_d        = S_DISCH;
                    timer_d        = '0;
                    ovr_d          = 1'b0;
                end
`endif
                if (done && !retry) begin
                    res_cnt_d   = count_q;
                    res_sign_d  = !p_q;
                    res_ch_d    = ch_q;
                    res_range_d = cur_range;
                    res_ovr_d   = ovr_fin;
                    ovr_d       = ovr_fin;
                    valid_d     = 1'b1;
                    state_d     = S_RESULT;
                end
            end
            S_RESULT: begin
                if (valid_q && result_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_SELECT;
`ifdef AUTORANGE_EN
                    // Underrange: use a more sensitive range on this channel's next conversion
                    if (!res_ovr_q && (res_cnt_q < CNT_W'(UNDER_TH)) &&
                        (range_q[res_ch_q] != 5'd0)) begin
                        range_d[res_ch_q] = range_q[res_ch_q] - 5'd1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            mask_q      <= '0;
            ch_q        <= '0;
            mode_q      <= '0;
            first_q     <= 1'b0;
            timer_q     <= '0;
            count_q     <= '0;
            p_q         <= 1'b0;
            ovr_q       <= 1'b0;
            valid_q     <= 1'b0;
            res_cnt_q   <= '0;
            res_sign_q  <= 1'b0;
            res_ch_q    <= '0;
            res_range_q <= '0;
            res_ovr_q   <= 1'b0;
`ifdef AUTORANGE_EN
            for (int k = 0; k < NUM_CH; k++) range_q[k] <= RANGE_TOP;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            mode_q      <= mode_d;
            first_q     <= first_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            p_q         <= p_d;
            ovr_q       <= ovr_d;
            valid_q     <= valid_d;
            res_cnt_q   <= res_cnt_d;
            res_sign_q  <= res_sign_d;
            res_ch_q    <= res_ch_d;
            res_range_q <= res_range_d;
            res_ovr_q   <= res_ovr_d;
`ifdef AUTORANGE_EN
            range_q     <= range_d;
`endif
        end
    end

    always_comb begin
        afe_sel_o = 4'b0000;
        case (state_q)
            S_AZ:    afe_sel_o = 4'b0001;
            S_INT:   afe_sel_o = 4'b0010;
            S_DEINT: afe_sel_o = p_q ? 4'b1000 : 4'b0100;
            default: afe_sel_o = 4'b0000;
        endcase
    end

    // Integrator is held discharged whenever it is not actively in use
    assign afe_reset_o    = !((state_q == S_AZ) || (state_q == S_INT) || (state_q == S_DEINT));
    assign ref_sign_o     = (state_q == S_DEINT) && p_q;
    assign range_sel_o    = cur_range;
    assign mode_sel_o     = mode_q;
    assign ch_sel_o       = ch_q;
    assign busy_o         = (state_q != S_IDLE);
    assign result_valid_o = valid_q;
    assign result_o       = res_cnt_q;
    assign result_sign_o  = res_sign_q;
    assign result_ch_o    = res_ch_q;
    assign result_range_o = res_range_q;
    assign result_ovr_o   = res_ovr_q;

endmodule

// File: tb/tb_meas_seq_mc.sv
module tb_meas_seq_mc;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        continuous_i = 1'b0;
    logic [3:0]  ch_mask_i = 4'b0000;
    logic [11:0] mode_cfg_i = {3'd4, 3'd3, 3'd2, 3'd1};
    logic        comp_i = 1'b1;
    logic        sat_hi_i = 1'b0;
    logic        sat_lo_i = 1'b0;
    logic        ref_ok_i = 1'b1;
    logic [3:0]  afe_sel_o;
    logic [4:0]  range_sel_o;
    logic        afe_reset_o;
    logic        ref_sign_o;
    logic [2:0]  mode_sel_o;
    logic [1:0]  ch_sel_o;
    logic        busy_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b1;
    logic [15:0] result_o;
    logic        result_sign_o;
    logic [1:0]  result_ch_o;
    logic [4:0]  result_range_o;
    logic        result_ovr_o;

    meas_seq_mc #(
        .NUM_CH(4), .CNT_W(16), .T_RST(4), .T_AZ(8), .T_INT(100),
        .N_RANGE(5), .UNDER_DIV(10)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .continuous_i(continuous_i), .ch_mask_i(ch_mask_i), .mode_cfg_i(mode_cfg_i),
        .comp_i(comp_i), .sat_hi_i(sat_hi_i), .sat_lo_i(sat_lo_i), .ref_ok_i(ref_ok_i),
        .afe_sel_o(afe_sel_o), .range_sel_o(range_sel_o), .afe_reset_o(afe_reset_o),
        .ref_sign_o(ref_sign_o), .mode_sel_o(mode_sel_o), .ch_sel_o(ch_sel_o),
        .busy_o(busy_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_o(result_o), .result_sign_o(result_sign_o), .result_ch_o(result_ch_o),
        .result_range_o(result_range_o), .result_ovr_o(result_ovr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cnt; int sign; int ch; int rng; int ovr; int mode;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    function automatic exp_t mk(int cnt, int sign, int ch, int rng, int ovr);
        exp_t e;
        e.cnt = cnt; e.sign = sign; e.ch = ch; e.rng = rng; e.ovr = ovr; e.mode = ch + 1;
        return e;
    endfunction

    // Monitor: pops one expected result per valid&&ready transfer
    always @(negedge clk_i) begin
        if (!rst_i && result_valid_o && result_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result ch=%0d count=%0d expected=none", result_ch_o, result_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_count", int'(result_o), mon_e.cnt);
                chk("res_sign", int'(result_sign_o), mon_e.sign);
                chk("res_ch", int'(result_ch_o), mon_e.ch);
                chk("res_range", int'(result_range_o), mon_e.rng);
                chk("res_ovr", int'(result_ovr_o), mon_e.ovr);
                chk("res_mode", int'(mode_sel_o), mon_e.mode);
            end
        end
    end

    // Comparator model: comp_int through INT, flips cross_k cycles into DEINT (-1 = never)
    logic       comp_int = 1'b1;
    int         cross_k = 30;
    int         deint_n = 0;
    logic [3:0] deint_sel = 4'd0;
    logic       deint_ref = 1'b0;
    always @(posedge clk_i) begin
        #1;
        if (afe_sel_o[2] || afe_sel_o[3]) begin
            deint_sel = afe_sel_o;
            deint_ref = ref_sign_o;
            comp_i = (cross_k >= 0 && deint_n >= cross_k) ? !comp_int : comp_int;
            deint_n++;
        end else begin
            deint_n = 0;
            comp_i = comp_int;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic start_scan(logic [3:0] m);
        ch_mask_i = m;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(string nm, int budget);
        int c = 0;
        while (busy_o && c < budget) begin
            tick(1);
            c++;
        end
        chk(nm, int'(busy_o), 0);
    endtask

    int rexp;
    int stable;
    int c;
    logic [15:0] hold_res;
    logic [1:0]  hold_ch;

    initial begin
        tick(3);
        chk("rst_afe_sel", int'(afe_sel_o), 0);
        chk("rst_afe_reset", int'(afe_reset_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_valid", int'(result_valid_o), 0);
        chk("rst_range_sel", int'(range_sel_o), 4);
        chk("rst_result", int'(result_o), 0);
        chk("rst_ch_mode", int'({ch_sel_o, mode_sel_o, ref_sign_o}), 0);
        rst_i = 1'b0;
        tick(2);

        // Positive input, mask 0101 single scan
        comp_int = 1'b1; cross_k = 30;
        exp_q.push_back(mk(32, 0, 0, 4, 0));
        exp_q.push_back(mk(32, 0, 2, 4, 0));
        start_scan(4'b0101);
        chk("t1_busy", int'(busy_o), 1);
        wait_idle("t1_idle", 1000);
        chk("t1_deint_sel", int'(deint_sel), 8);
        chk("t1_ref_sign", int'(deint_ref), 1);
        chk("t1_drained", exp_q.size(), 0);
        chk("t1_idle_sel", int'(afe_sel_o), 0);
        chk("t1_idle_reset", int'(afe_reset_o), 1);

        // Negative input
        comp_int = 1'b0; cross_k = 50;
        exp_q.push_back(mk(52, 1, 1, 4, 0));
        start_scan(4'b0010);
        wait_idle("t2_idle", 1000);
        chk("t2_deint_sel", int'(deint_sel), 4);
        chk("t2_ref_sign", int'(deint_ref), 0);

        // No crossing -> capped overrange; also reference wait
        comp_int = 1'b1; cross_k = -1;
        ref_ok_i = 1'b0;
        exp_q.push_back(mk(200, 0, 3, 4, 1));
        start_scan(4'b1000);
        tick(20);
        chk("t3_waitref_busy", int'(busy_o), 1);
        chk("t3_waitref_sel", int'(afe_sel_o), 0);
        chk("t3_waitref_reset", int'(afe_reset_o), 1);
        ref_ok_i = 1'b1;
        wait_idle("t3_idle", 1000);

        // Underrange then re-conversion of the same channel
        cross_k = 3;
        exp_q.push_back(mk(5, 0, 0, 4, 0));
        start_scan(4'b0001);
        wait_idle("t4a_idle", 1000);
`ifdef AUTORANGE_EN
        rexp = 3;
`else
        rexp = 4;
`endif
        cross_k = 30;
        exp_q.push_back(mk(32, 0, 0, rexp, 0));
        start_scan(4'b0001);
        tick(20);
        chk("t4_range_sel", int'(range_sel_o), rexp);
        wait_idle("t4b_idle", 1000);

        // Backpressure
        result_ready_i = 1'b0;
        exp_q.push_back(mk(32, 0, 0, rexp, 0));
        exp_q.push_back(mk(32, 0, 1, 4, 0));
        start_scan(4'b0011);
        c = 0;
        while (!result_valid_o && c < 500) begin
            tick(1);
            c++;
        end
        chk("t5_valid", int'(result_valid_o), 1);
        hold_res = result_o;
        hold_ch  = result_ch_o;
        stable = 1;
        repeat (50) begin
            tick(1);
            if (result_o != hold_res || result_ch_o != hold_ch || !result_valid_o ||
                !afe_reset_o || afe_sel_o != 4'd0) stable = 0;
        end
        chk("t5_hold_stable", stable, 1);
        result_ready_i = 1'b1;
        tick(4);
        chk("t5_next_ch", int'(ch_sel_o), 1);
        chk("t5_valid_drop", int'(result_valid_o), 0);
        wait_idle("t5_idle", 1000);

        // Continuous wrap on a single channel, then abort
        continuous_i = 1'b1;
        exp_q.push_back(mk(32, 0, 2, 4, 0));
        exp_q.push_back(mk(32, 0, 2, 4, 0));
        start_scan(4'b0100);
        c = 0;
        while (exp_q.size() != 0 && c < 1000) begin
            tick(1);
            c++;
        end
        chk("t6_wrap_drained", exp_q.size(), 0);
        chk("t6_still_busy", int'(busy_o), 1);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        continuous_i = 1'b0;
        chk("t6_abort_busy", int'(busy_o), 0);

        // Abort during INT
        start_scan(4'b0001);
        c = 0;
        while (afe_sel_o != 4'b0010 && c < 200) begin
            tick(1);
            c++;
        end
        chk("t7_in_int", int'(afe_sel_o), 2);
        tick(10);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        chk("t7_abort_sel", int'(afe_sel_o), 0);
        chk("t7_abort_reset", int'(afe_reset_o), 1);
        chk("t7_abort_busy", int'(busy_o), 0);
        chk("t7_abort_valid", int'(result_valid_o), 0);
        tick(300);
        chk("t7_no_result", int'(result_valid_o), 0);

        // Zero mask is ignored
        start_scan(4'b0000);
        tick(3);
        chk("t8_zero_mask", int'(busy_o), 0);

        chk("final_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
